// File: rtl/lcd_text_feeder.sv
// lcd_text_feeder: buffers an ASCII character stream in a small FIFO, tracks
// the cursor on a ROWS x COLS display and turns each character into LCD
// controller transactions ({rs, rw, data}) paced by the controller's busy.
// Optional feature: define LCD_AUTOWRAP_EN to wrap a printable character
// written past the last column onto the next row (set-address, then write).
module lcd_text_feeder #(
  parameter int COLS        = 16,
  parameter int ROWS        = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 4,
  localparam int CW         = $clog2(COLS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_char,
  output logic          in_ready,
  input  logic          busy,
  output logic          lcd_enable,
  output logic [9:0]    lcd_bus,
  output logic          cur_row,
  output logic [CW-1:0] cur_col,
  output logic          idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [9:0] HOME_CMD  = 10'h080;
  localparam logic [9:0] CLEAR_CMD = 10'h001;

  typedef enum logic [2:0] {IDLE, DECODE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t          state_reg, state_next;
  logic [9:0]      cmd_reg, cmd_next;
  logic            row_reg, row_next;
  logic [CW-1:0]   col_reg, col_next;
  logic            pending_home_reg, pending_home_next;
  logic [TW-1:0]   tmo_reg, tmo_next;
  logic            lcd_enable_reg, lcd_enable_next;
  logic [9:0]      lcd_bus_reg, lcd_bus_next;
  logic            idle_reg, idle_next;
  logic            in_ready_reg, in_ready_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg, count_next;
  logic [7:0]      char_reg;
  logic [7:0]      mem [FIFO_DEPTH];
  logic            push, pop;
`ifdef LCD_AUTOWRAP_EN
  logic            wrap_reg, wrap_next;
`endif

  // DDRAM set-address command byte (0x80 | row base) for a given row.
  function automatic logic [7:0] row_addr(input logic r);
    return (ROWS == 2 && r) ? 8'hC0 : 8'h80;
  endfunction

  // Row that follows r, wrapping on the last display line.
  function automatic logic next_row(input logic r);
    return (ROWS == 2) ? ~r : 1'b0;
  endfunction

  assign in_ready   = in_ready_reg;
  assign lcd_enable = lcd_enable_reg;
  assign lcd_bus    = lcd_bus_reg;
  assign cur_row    = row_reg;
  assign cur_col    = col_reg;
  assign idle       = idle_reg;

  // Character storage and registered read into the decode register.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_char;
    if (pop)  char_reg <= mem[rd_ptr_reg];
  end

  // State, cursor, FIFO pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      cmd_reg          <= '0;
      row_reg          <= 1'b0;
      col_reg          <= '0;
      pending_home_reg <= 1'b1;
      tmo_reg          <= '0;
      lcd_enable_reg   <= 1'b0;
      lcd_bus_reg      <= '0;
      idle_reg         <= 1'b0;
      in_ready_reg     <= 1'b1;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
`ifdef LCD_AUTOWRAP_EN
      wrap_reg         <= 1'b0;
`endif
    end else begin
      state_reg        <= state_next;
      cmd_reg          <= cmd_next;
      row_reg          <= row_next;
      col_reg          <= col_next;
      pending_home_reg <= pending_home_next;
      tmo_reg          <= tmo_next;
      lcd_enable_reg   <= lcd_enable_next;
      lcd_bus_reg      <= lcd_bus_next;
      idle_reg         <= idle_next;
      in_ready_reg     <= in_ready_next;
      count_reg        <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
`ifdef LCD_AUTOWRAP_EN
      wrap_reg         <= wrap_next;
`endif
    end
  end

  // Next-state, command decode, handshake pacing and FIFO bookkeeping.
  always_comb begin
    state_next        = state_reg;
    cmd_next          = cmd_reg;
    row_next          = row_reg;
    col_next          = col_reg;
    pending_home_next = pending_home_reg;
    tmo_next          = tmo_reg;
    lcd_enable_next   = 1'b0;
    lcd_bus_next      = lcd_bus_reg;
    pop               = 1'b0;
    push              = in_valid && in_ready_reg;
`ifdef LCD_AUTOWRAP_EN
    wrap_next         = wrap_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (pending_home_reg) begin
          cmd_next   = HOME_CMD;
          state_next = ISSUE;
        end else if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = DECODE;
        end
      end

      DECODE: begin
        state_next = ISSUE;
        if (char_reg == 8'h0C) begin
          cmd_next = CLEAR_CMD;
          row_next = 1'b0;
          col_next = '0;
        end else if (char_reg == 8'h0A) begin
          row_next = next_row(row_reg);
          col_next = '0;
          cmd_next = {2'b00, row_addr(next_row(row_reg))};
        end else if (char_reg == 8'h0D) begin
          col_next = '0;
          cmd_next = {2'b00, row_addr(row_reg)};
        end else if (char_reg >= 8'h20 && char_reg <= 8'h7E) begin
          if (col_reg != CW'(COLS)) begin
            cmd_next = {2'b10, char_reg};
            col_next = col_reg + CW'(1);
          end else begin
`ifdef LCD_AUTOWRAP_EN
            // Move to the start of the next row first; the character
            // itself is written once this address command completes.
            row_next  = next_row(row_reg);
            col_next  = '0;
            cmd_next  = {2'b00, row_addr(next_row(row_reg))};
            wrap_next = 1'b1;
`else
            state_next = IDLE;
`endif
          end
        end else begin
          state_next = IDLE;
        end
      end

      ISSUE: begin
        if (!busy) begin
          lcd_enable_next = 1'b1;
          lcd_bus_next    = cmd_reg;
          tmo_next        = '0;
          state_next      = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (busy) begin
          state_next = WAIT_DONE;
        end else if (tmo_reg == TW'(ACK_TIMEOUT - 1)) begin
          // Controller never acknowledged the strobe: pulse it again.
          state_next = ISSUE;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
      end

      WAIT_DONE: begin
        if (!busy) begin
          // Home is only ever in flight while pending_home is set.
          pending_home_next = 1'b0;
          state_next        = IDLE;
`ifdef LCD_AUTOWRAP_EN
          if (wrap_reg) begin
            wrap_next  = 1'b0;
            cmd_next   = {2'b10, char_reg};
            col_next   = CW'(1);
            state_next = ISSUE;
          end
`endif
        end
      end

      default: state_next = IDLE;
    endcase

    case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase

    in_ready_next = (count_next != (AW+1)'(FIFO_DEPTH));
    idle_next     = (state_next == IDLE) && (count_next == '0) && !pending_home_next;
  end

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Directed testbench for lcd_text_feeder with a small LCD controller model
// that logs every strobe and answers it with a 3-cycle busy pulse.
module tb_lcd_text_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic       busy;
  logic       lcd_enable;
  logic [9:0] lcd_bus;
  logic       cur_row;
  logic [4:0] cur_col;
  logic       idle;

  logic       force_busy;
  logic       model_busy = 1'b0;
  logic       auto_ack;
  int         busy_cnt = 0;
  int         cyc = 0;
  logic [9:0] pulses[$];

  int nvec = 0;
  int nerr = 0;

  assign busy = force_busy | model_busy;

  lcd_text_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .busy       (busy),
    .lcd_enable (lcd_enable),
    .lcd_bus    (lcd_bus),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Controller model: log each strobe, acknowledge with busy for 3 cycles.
  always @(negedge clk) begin
    if (busy_cnt != 0) busy_cnt = busy_cnt - 1;
    if (lcd_enable) begin
      pulses.push_back(lcd_bus);
      if (auto_ack) busy_cnt = 3;
    end
    model_busy = (busy_cnt != 0);
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic push(input logic [7:0] c);
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!(idle && !busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) check_vec("idle_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    int acc;
    int seen;
    int t[3];
    logic [9:0] got_bus;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_char    = 8'h00;
    force_busy = 1'b0;
    auto_ack   = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_vec("rst_lcd_enable", 32'(lcd_enable), 32'd0);
    check_vec("rst_lcd_bus", 32'(lcd_bus), 32'd0);
    check_vec("rst_cur_row", 32'(cur_row), 32'd0);
    check_vec("rst_cur_col", 32'(cur_col), 32'd0);
    check_vec("rst_in_ready", 32'(in_ready), 32'd1);
    check_vec("rst_idle", 32'(idle), 32'd0);

    // Release: exactly one home command, then idle.
    pulses.delete();
    rst_n = 1'b1;
    wait_idle(200);
    check_vec("home_count", 32'(pulses.size()), 32'd1);
    if (pulses.size() > 0) check_vec("home_cmd", 32'(pulses[0]), 32'h080);
    repeat (10) @(negedge clk);
    check_vec("home_no_more", 32'(pulses.size()), 32'd1);

    // 'A' at row 0 col 0: latency and command.
    pulses.delete();
    push(8'h41);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_vec("A_col_at_decode", 32'(cur_col), 32'd1);
    check_vec("A_no_enable_yet", 32'(lcd_enable), 32'd0);
    @(negedge clk);
    check_vec("A_enable", 32'(lcd_enable), 32'd1);
    check_vec("A_bus", 32'(lcd_bus), 32'h241);
    @(negedge clk);
    check_vec("A_enable_one_cycle", 32'(lcd_enable), 32'd0);
    wait_idle(200);

    // Line feed moves to row 1.
    push(8'h0A);
    wait_idle(200);
    check_vec("LF_count", 32'(pulses.size()), 32'd2);
    if (pulses.size() == 2) check_vec("LF_cmd", 32'(pulses[1]), 32'h0C0);
    check_vec("LF_row", 32'(cur_row), 32'd1);
    check_vec("LF_col", 32'(cur_col), 32'd0);

    // Form feed clears and homes the cursor.
    pulses.delete();
    push(8'h0C);
    wait_idle(200);
    check_vec("FF_count", 32'(pulses.size()), 32'd1);
    if (pulses.size() == 1) check_vec("FF_cmd", 32'(pulses[0]), 32'h001);
    check_vec("FF_row", 32'(cur_row), 32'd0);

    // 17 x 'B' on row 0: overflow of the last column.
    pulses.delete();
    for (int i = 0; i < 17; i++) begin
      push(8'h42);
      wait_idle(200);
    end
`ifdef LCD_AUTOWRAP_EN
    check_vec("row_fill_count", 32'(pulses.size()), 32'd18);
    if (pulses.size() == 18) begin
      check_vec("wrap_addr", 32'(pulses[16]), 32'h0C0);
      check_vec("wrap_char", 32'(pulses[17]), 32'h242);
    end
    check_vec("wrap_row", 32'(cur_row), 32'd1);
    check_vec("wrap_col", 32'(cur_col), 32'd1);
`else
    check_vec("row_fill_count", 32'(pulses.size()), 32'd16);
    acc = 0;
    foreach (pulses[i]) if (pulses[i] == 10'h242) acc++;
    check_vec("row_fill_all_B", 32'(acc), 32'd16);
    check_vec("row_fill_row", 32'(cur_row), 32'd0);
    check_vec("row_fill_col", 32'(cur_col), 32'd16);
`endif

    // Unprintable control code is dropped.
    pulses.delete();
    push(8'h01);
    wait_idle(200);
    check_vec("drop_ctrl", 32'(pulses.size()), 32'd0);

    // Busy held: FIFO fills, nothing issued, then drains in order.
    push(8'h0C);
    wait_idle(200);
    pulses.delete();
    force_busy = 1'b1;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      acc += int'(in_ready);
      in_valid = 1'b1;
      in_char  = 8'h41 + 8'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_vec("fill_accepted", 32'(acc), 32'd9);
    check_vec("fill_in_ready_low", 32'(in_ready), 32'd0);
    repeat (20) @(negedge clk);
    check_vec("fill_no_pulse_busy", 32'(pulses.size()), 32'd0);
    force_busy = 1'b0;
    wait_idle(400);
    check_vec("fill_drain_count", 32'(pulses.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      got_bus = (i < pulses.size()) ? pulses[i] : 10'h3FF;
      check_vec("fill_drain_order", 32'(got_bus), 32'({2'b10, 8'h41 + 8'(i)}));
    end
    check_vec("fill_col", 32'(cur_col), 32'd9);

    // No acknowledge: retries every ACK_TIMEOUT+1 cycles.
    pulses.delete();
    auto_ack = 1'b0;
    push(8'h5A);
    seen = 0;
    for (int k = 0; k < 100 && seen < 3; k++) begin
      @(negedge clk);
      if (lcd_enable) begin
        t[seen] = cyc;
        seen++;
      end
    end
    force_busy = 1'b1;
    check_vec("retry_seen", 32'(seen), 32'd3);
    if (seen == 3) begin
      check_vec("retry_gap1", 32'(t[1] - t[0]), 32'd5);
      check_vec("retry_gap2", 32'(t[2] - t[1]), 32'd5);
    end
    repeat (3) @(negedge clk);
    force_busy = 1'b0;
    auto_ack   = 1'b1;
    wait_idle(200);
    check_vec("retry_stops", 32'(pulses.size()), 32'd3);
    acc = 0;
    foreach (pulses[i]) if (pulses[i] == 10'h25A) acc++;
    check_vec("retry_same_cmd", 32'(acc), 32'd3);

    // Reset during WAIT_DONE with characters still queued.
    push(8'h51);
    push(8'h52);
    push(8'h53);
    seen = 0;
    for (int k = 0; k < 50 && seen == 0; k++) begin
      @(negedge clk);
      if (lcd_enable) seen = 1;
    end
    check_vec("mid_rst_pulse_seen", 32'(seen), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_vec("mid_rst_enable", 32'(lcd_enable), 32'd0);
    check_vec("mid_rst_bus", 32'(lcd_bus), 32'd0);
    check_vec("mid_rst_col", 32'(cur_col), 32'd0);
    check_vec("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check_vec("mid_rst_idle", 32'(idle), 32'd0);
    repeat (2) @(negedge clk);
    pulses.delete();
    rst_n = 1'b1;
    wait_idle(200);
    repeat (10) @(negedge clk);
    check_vec("mid_rst_count", 32'(pulses.size()), 32'd1);
    if (pulses.size() > 0) check_vec("mid_rst_home", 32'(pulses[0]), 32'h080);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
